// File: rtl/fft_psd_reader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fft_psd_reader_if
//  Purpose  : Bundle of the handshake and data signals between an upstream
//             FFT output port / downstream power consumer and the
//             fft_psd_reader block.
//  Revision : 1.0 - initial release
//  Ports    : (none; pure signal bundle)
//    clear_i          synchronous flush request
//    fft_in_*         complex bin stream in  {re, im}, valid/ready
//    pwr_*            power stream out {data, bin, last}, valid/ready
//    peak_*           per-frame peak report
//  Modports : master - the environment around the reader (drives inputs)
//             slave  - the reader itself
// ============================================================================
interface fft_psd_reader_if #(
  parameter int FFT_SIZE   = 16,
  parameter int DATA_WIDTH = 16
);
  localparam int LB = $clog2(FFT_SIZE);
  localparam int PW = 2 * DATA_WIDTH;

  logic          clear_i;
  logic          fft_in_valid_i;
  logic [PW-1:0] fft_in_data_i;
  logic          fft_in_ready_o;
  logic          pwr_valid_o;
  logic [PW-1:0] pwr_data_o;
  logic [LB-1:0] pwr_bin_o;
  logic          pwr_last_o;
  logic          pwr_ready_i;
  logic          peak_valid_o;
  logic [LB-1:0] peak_bin_o;
  logic [PW-1:0] peak_pwr_o;

  modport master (
    output clear_i,
    output fft_in_valid_i,
    output fft_in_data_i,
    input  fft_in_ready_o,
    input  pwr_valid_o,
    input  pwr_data_o,
    input  pwr_bin_o,
    input  pwr_last_o,
    output pwr_ready_i,
    input  peak_valid_o,
    input  peak_bin_o,
    input  peak_pwr_o
  );

  modport slave (
    input  clear_i,
    input  fft_in_valid_i,
    input  fft_in_data_i,
    output fft_in_ready_o,
    output pwr_valid_o,
    output pwr_data_o,
    output pwr_bin_o,
    output pwr_last_o,
    input  pwr_ready_i,
    output peak_valid_o,
    output peak_bin_o,
    output peak_pwr_o
  );
endinterface
`default_nettype wire

// File: rtl/fft_psd_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fft_psd_reader
//  Purpose  : Output reader for the FFT core. Accepts one frame of FFT_SIZE
//             complex bins, computes |X|^2 per bin in a two-stage pipeline,
//             buffers the results in a first-word-fall-through FIFO and
//             re-emits them tagged with bin index and end-of-frame marker.
//             Also tracks and reports the peak bin of every frame.
//  Revision : 1.0 - initial release
//  Ports    :
//    clk_i             clock
//    rst_ni            asynchronous active-low reset
//    bus (slave)       clear_i        synchronous flush
//                      fft_in_*       input bins {re, im}, valid/ready
//                      pwr_*          power out {data, bin, last}, valid/ready
//                      peak_*         peak of last completed frame + pulse
// ============================================================================
module fft_psd_reader #(
  parameter int FFT_SIZE   = 16,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  fft_psd_reader_if.slave bus
);

  localparam int LB = $clog2(FFT_SIZE);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [LB-1:0]         c_LAST_BIN = LB'(FFT_SIZE - 1);
  localparam logic [LB-1:0]         c_BIN_ONE  = {{(LB-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]         c_PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]           c_CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]           c_DEPTH    = (AW+1)'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] c_DW_ONE   = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Input handshake and bin counter
  // --------------------------------------------------------------------------
  logic          w_in_ready;
  logic          w_accept;
  logic [LB-1:0] r_bin_cnt;

  // --------------------------------------------------------------------------
  // Stage 1: squared magnitudes of re and im
  // --------------------------------------------------------------------------
  // Squaring via the magnitude keeps the multiply unsigned. |-2^(DW-1)| is
  // exactly 2^(DW-1), which is representable as an unsigned DW-bit value.
  logic [DATA_WIDTH-1:0] w_re_raw;
  logic [DATA_WIDTH-1:0] w_im_raw;
  logic [DATA_WIDTH-1:0] w_re_mag;
  logic [DATA_WIDTH-1:0] w_im_mag;
  logic [PW-2:0]         w_re_ext;
  logic [PW-2:0]         w_im_ext;
  logic [PW-2:0]         w_re_sq;
  logic [PW-2:0]         w_im_sq;

  assign w_re_raw = bus.fft_in_data_i[PW-1:DATA_WIDTH];
  assign w_im_raw = bus.fft_in_data_i[DATA_WIDTH-1:0];
  assign w_re_mag = w_re_raw[DATA_WIDTH-1] ? (~w_re_raw + c_DW_ONE) : w_re_raw;
  assign w_im_mag = w_im_raw[DATA_WIDTH-1] ? (~w_im_raw + c_DW_ONE) : w_im_raw;

  // Widen before multiplying so the product is computed at PW-1 bits; the
  // largest square 2^(PW-2) fits.
  assign w_re_ext = {{(DATA_WIDTH-1){1'b0}}, w_re_mag};
  assign w_im_ext = {{(DATA_WIDTH-1){1'b0}}, w_im_mag};
  assign w_re_sq  = w_re_ext * w_re_ext;
  assign w_im_sq  = w_im_ext * w_im_ext;

  logic          r_s1_valid;
  logic [PW-2:0] r_s1_re_sq;
  logic [PW-2:0] r_s1_im_sq;
  logic [LB-1:0] r_s1_bin;

  assign w_accept = bus.fft_in_valid_i && w_in_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bin_cnt  <= '0;
      r_s1_valid <= 1'b0;
      r_s1_re_sq <= '0;
      r_s1_im_sq <= '0;
      r_s1_bin   <= '0;
    end else if (bus.clear_i) begin
      r_bin_cnt  <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_re_sq <= w_re_sq;
        r_s1_im_sq <= w_im_sq;
        r_s1_bin   <= r_bin_cnt;
        // FFT_SIZE is a power of two, so the natural LB-bit wrap takes the
        // counter from FFT_SIZE-1 back to 0.
        r_bin_cnt  <= r_bin_cnt + c_BIN_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: power sum, FIFO write and peak update
  // --------------------------------------------------------------------------
  // S2 is the adder sitting between the S1 registers and the FIFO write port;
  // it has no register of its own, so its valid and its occupancy are those
  // of the entry held in S1.
  logic          w_s2_valid;
  logic [PW-1:0] w_s2_pwr;
  logic          w_s2_last;

  assign w_s2_valid = r_s1_valid;
  assign w_s2_pwr   = {1'b0, r_s1_re_sq} + {1'b0, r_s1_im_sq};
  assign w_s2_last  = (r_s1_bin == c_LAST_BIN);

  // --------------------------------------------------------------------------
  // Output FIFO (first-word-fall-through)
  // --------------------------------------------------------------------------
  logic [PW-1:0] r_mem_pwr  [FIFO_DEPTH];
  logic [LB-1:0] r_mem_bin  [FIFO_DEPTH];
  logic          r_mem_last [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;
  logic          w_out_valid;
  logic [AW:0]   w_occupancy;

  assign w_out_valid = (r_count != '0);
  assign w_push      = w_s2_valid && !bus.clear_i;
  assign w_pop       = w_out_valid && bus.pwr_ready_i && !bus.clear_i;

  // Credit: every entry already in the FIFO or still in flight in the
  // pipeline holds a slot, so a push can never find the FIFO full.
  assign w_occupancy = r_count + {{AW{1'b0}}, r_s1_valid};
  assign w_in_ready  = !bus.clear_i && (w_occupancy < c_DEPTH);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: reads are masked to zero while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_pwr[r_wr_ptr]  <= w_s2_pwr;
      r_mem_bin[r_wr_ptr]  <= r_s1_bin;
      r_mem_last[r_wr_ptr] <= w_s2_last;
    end
  end

  assign bus.fft_in_ready_o = w_in_ready;
  assign bus.pwr_valid_o    = w_out_valid;
  assign bus.pwr_data_o     = w_out_valid ? r_mem_pwr[r_rd_ptr]  : '0;
  assign bus.pwr_bin_o      = w_out_valid ? r_mem_bin[r_rd_ptr]  : '0;
  assign bus.pwr_last_o     = w_out_valid ? r_mem_last[r_rd_ptr] : 1'b0;

  // --------------------------------------------------------------------------
  // Peak tracker
  // --------------------------------------------------------------------------
  // Bin 0 always seeds the running peak; later bins win only when strictly
  // greater, so on ties the lower bin index is kept.
  logic [PW-1:0] r_run_pwr;
  logic [LB-1:0] r_run_bin;
  logic          w_s2_take;
  logic [PW-1:0] w_best_pwr;
  logic [LB-1:0] w_best_bin;
  logic          r_peak_valid;
  logic [LB-1:0] r_peak_bin;
  logic [PW-1:0] r_peak_pwr;

  assign w_s2_take  = (r_s1_bin == '0) || (w_s2_pwr > r_run_pwr);
  assign w_best_pwr = w_s2_take ? w_s2_pwr : r_run_pwr;
  assign w_best_bin = w_s2_take ? r_s1_bin : r_run_bin;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_run_pwr    <= '0;
      r_run_bin    <= '0;
      r_peak_valid <= 1'b0;
      r_peak_bin   <= '0;
      r_peak_pwr   <= '0;
    end else if (bus.clear_i) begin
      // The reported peak of the last completed frame is left untouched.
      r_run_pwr    <= '0;
      r_run_bin    <= '0;
      r_peak_valid <= 1'b0;
    end else begin
      r_peak_valid <= 1'b0;
      if (w_s2_valid) begin
        r_run_pwr <= w_best_pwr;
        r_run_bin <= w_best_bin;
        if (w_s2_last) begin
          r_peak_pwr   <= w_best_pwr;
          r_peak_bin   <= w_best_bin;
          r_peak_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.peak_valid_o = r_peak_valid;
  assign bus.peak_bin_o   = r_peak_bin;
  assign bus.peak_pwr_o   = r_peak_pwr;

endmodule
`default_nettype wire

// File: tb/tb_fft_psd_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fft_psd_reader
//  Purpose  : Directed self-checking bench for fft_psd_reader: reset values,
//             impulse/extreme/tie frames, backpressure, clear, random frames
//             and asynchronous reset mid-frame.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fft_psd_reader;

  localparam int FFT_SIZE = 16;
  localparam int DW       = 16;
  localparam int DEPTH    = 4;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  always #5 clk_i = ~clk_i;

  fft_psd_reader_if #(.FFT_SIZE(FFT_SIZE), .DATA_WIDTH(DW)) bus ();

  fft_psd_reader #(
    .FFT_SIZE  (FFT_SIZE),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model and scoreboard
  // --------------------------------------------------------------------------
  typedef struct { logic [31:0] pwr; logic [3:0] bin; logic last; } exp_t;
  typedef struct { logic [3:0] bin; logic [31:0] pwr; } pk_t;

  exp_t        exp_q[$];
  pk_t         pk_q[$];
  logic [3:0]  m_bin = '0;
  logic [31:0] m_run = '0;
  logic [3:0]  m_run_bin = '0;

  logic [31:0] obs_pwr [16];
  logic        obs_last[16];
  int          obs_bins[$];
  int          n_out  = 0;
  int          n_peak = 0;
  int          n_acc  = 0;
  logic [31:0] frame  [32];

  function automatic logic [31:0] psd(input logic [31:0] d);
    longint re;
    longint im;
    re = longint'($signed(d[31:16]));
    im = longint'($signed(d[15:0]));
    return 32'(re * re + im * im);
  endfunction

  task automatic model_clear();
    exp_q.delete();
    pk_q.delete();
    m_bin     = '0;
    m_run     = '0;
    m_run_bin = '0;
  endtask

  task automatic model_accept(input logic [31:0] d);
    exp_t        e;
    pk_t         pk;
    logic [31:0] p;
    p      = psd(d);
    e.pwr  = p;
    e.bin  = m_bin;
    e.last = (m_bin == 4'd15);
    exp_q.push_back(e);
    if (m_bin == 4'd0 || p > m_run) begin
      m_run     = p;
      m_run_bin = m_bin;
    end
    if (m_bin == 4'd15) begin
      pk.bin = m_run_bin;
      pk.pwr = m_run;
      pk_q.push_back(pk);
    end
    m_bin = m_bin + 4'd1;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 16; i++) begin
      obs_pwr[i]  = 32'hDEAD_BEEF;
      obs_last[i] = 1'bx;
    end
    obs_bins.delete();
    n_out = 0;
  endtask

  // Monitor: samples at the falling edge, mid-cycle.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      model_clear();
    end else begin
      if (bus.pwr_valid_o && bus.pwr_ready_i && !bus.clear_i) begin
        n_out++;
        obs_pwr[bus.pwr_bin_o]  = bus.pwr_data_o;
        obs_last[bus.pwr_bin_o] = bus.pwr_last_o;
        obs_bins.push_back(int'(bus.pwr_bin_o));
        if (exp_q.size() == 0) begin
          check_eq("sb_underflow", exp_q.size(), 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("sb_pwr", bus.pwr_data_o, e.pwr);
          check_eq("sb_bin", bus.pwr_bin_o, e.bin);
          check_eq("sb_last", bus.pwr_last_o, e.last);
        end
      end
      if (bus.peak_valid_o) begin
        n_peak++;
        if (pk_q.size() == 0) begin
          check_eq("peak_unexpected", pk_q.size(), 1);
        end else begin
          pk_t pk;
          pk = pk_q.pop_front();
          check_eq("sb_peak_bin", bus.peak_bin_o, pk.bin);
          check_eq("sb_peak_pwr", bus.peak_pwr_o, pk.pwr);
        end
      end
      if (bus.clear_i) begin
        model_clear();
      end else if (bus.fft_in_valid_i && bus.fft_in_ready_o) begin
        n_acc++;
        model_accept(bus.fft_in_data_i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic send_bin(input logic [31:0] d);
    int waitc = 0;
    bus.fft_in_valid_i = 1'b1;
    bus.fft_in_data_i  = d;
    @(negedge clk_i);
    while (!bus.fft_in_ready_o) begin
      waitc++;
      if (waitc > 300) begin
        check_eq("in_ready_timeout", bus.fft_in_ready_o, 1);
        break;
      end
      @(negedge clk_i);
    end
    @(posedge clk_i);
    #1;
    bus.fft_in_valid_i = 1'b0;
  endtask

  task automatic send_frames(input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      send_bin(frame[i]);
    end
  endtask

  task automatic wait_drain();
    int k = 0;
    @(negedge clk_i);
    while ((exp_q.size() != 0 || bus.pwr_valid_o) && k < 300) begin
      k++;
      @(negedge clk_i);
    end
    check_eq("drain_done", exp_q.size(), 0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_peak(input string tag, input logic [3:0] eb, input logic [31:0] ep);
    int k = 0;
    @(negedge clk_i);
    while (!bus.peak_valid_o && k < 20) begin
      k++;
      @(negedge clk_i);
    end
    check_eq({tag, "_pulse"}, bus.peak_valid_o, 1);
    check_eq({tag, "_bin"}, bus.peak_bin_o, eb);
    check_eq({tag, "_pwr"}, bus.peak_pwr_o, ep);
    @(negedge clk_i);
    check_eq({tag, "_one_cycle"}, bus.peak_valid_o, 0);
    check_eq({tag, "_hold_bin"}, bus.peak_bin_o, eb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, got timeout expected completion");
    $fatal(1);
  end

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int p0;
    int a0;
    bit tx_done;

    bus.clear_i        = 1'b0;
    bus.fft_in_valid_i = 1'b0;
    bus.fft_in_data_i  = '0;
    bus.pwr_ready_i    = 1'b0;
    clear_obs();

    repeat (3) @(posedge clk_i);
    #2;
    check_eq("rst_in_ready", bus.fft_in_ready_o, 1);
    check_eq("rst_pwr_valid", bus.pwr_valid_o, 0);
    check_eq("rst_pwr_data", bus.pwr_data_o, 0);
    check_eq("rst_pwr_bin", bus.pwr_bin_o, 0);
    check_eq("rst_pwr_last", bus.pwr_last_o, 0);
    check_eq("rst_peak_valid", bus.peak_valid_o, 0);
    check_eq("rst_peak_bin", bus.peak_bin_o, 0);
    check_eq("rst_peak_pwr", bus.peak_pwr_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // ---- Impulse frame with latency probe ----
    bus.pwr_ready_i = 1'b1;
    clear_obs();
    for (int i = 0; i < 16; i++) frame[i] = 32'h0;
    frame[3] = {16'h4000, 16'h0000};
    send_bin(frame[0]);
    check_eq("lat_one_cycle_not_valid", bus.pwr_valid_o, 0);
    send_bin(frame[1]);
    check_eq("lat_two_cycle_valid", bus.pwr_valid_o, 1);
    check_eq("lat_first_bin", bus.pwr_bin_o, 0);
    send_frames(2, 14);
    wait_peak("imp_peak", 4'd3, 32'h1000_0000);
    wait_drain();
    check_eq("imp_bin3_pwr", obs_pwr[3], 32'h1000_0000);
    check_eq("imp_bin0_pwr", obs_pwr[0], 32'h0);
    check_eq("imp_bin15_pwr", obs_pwr[15], 32'h0);
    check_eq("imp_last15", obs_last[15], 1);
    check_eq("imp_last14", obs_last[14], 0);
    check_eq("imp_count", n_out, 16);

    // ---- Extreme value ----
    clear_obs();
    for (int i = 0; i < 16; i++) frame[i] = 32'h0;
    frame[5] = {16'h8000, 16'h8000};
    fork
      send_frames(0, 16);
      wait_peak("ext_peak", 4'd5, 32'h8000_0000);
    join
    wait_drain();
    check_eq("ext_bin5_pwr", obs_pwr[5], 32'h8000_0000);

    // ---- Ties keep the lower bin ----
    clear_obs();
    for (int i = 0; i < 16; i++) frame[i] = {16'(i), 16'h0000};
    frame[2] = {16'd16, 16'd0};
    frame[9] = {16'd0, 16'd16};
    fork
      send_frames(0, 16);
      wait_peak("tie_peak", 4'd2, 32'h0000_0100);
    join
    wait_drain();
    check_eq("tie_bin9_pwr", obs_pwr[9], 32'h100);
    check_eq("tie_bin15_pwr", obs_pwr[15], 32'd225);

    // ---- Backpressure ----
    clear_obs();
    bus.pwr_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) frame[i] = {16'(i + 1), 16'h0000};
    a0 = n_acc;
    p0 = n_peak;
    fork
      send_frames(0, 16);
      begin
        repeat (10) @(posedge clk_i);
        #2;
        check_eq("bp_accepted", n_acc - a0, 4);
        check_eq("bp_ready_low", bus.fft_in_ready_o, 0);
        bus.pwr_ready_i = 1'b1;
      end
    join
    wait_drain();
    check_eq("bp_count", n_out, 16);
    for (int i = 0; i < 4; i++) check_eq("bp_order", obs_bins[i], i);
    check_eq("bp_peak_pulses", n_peak - p0, 1);
    check_eq("bp_peak_bin", bus.peak_bin_o, 4'd15);
    check_eq("bp_peak_pwr", bus.peak_pwr_o, 32'd256);

    // ---- Clear after 7 bins ----
    clear_obs();
    for (int i = 0; i < 16; i++) frame[i] = {16'(i * 100), 16'(3 * i)};
    p0 = n_peak;
    send_frames(0, 7);
    bus.clear_i        = 1'b1;
    bus.fft_in_valid_i = 1'b1;
    bus.fft_in_data_i  = 32'h1234_5678;
    @(negedge clk_i);
    check_eq("clr_ready_low", bus.fft_in_ready_o, 0);
    @(posedge clk_i);
    #1;
    bus.clear_i        = 1'b0;
    bus.fft_in_valid_i = 1'b0;
    check_eq("clr_fifo_empty", bus.pwr_valid_o, 0);
    check_eq("clr_hold_peak_bin", bus.peak_bin_o, 4'd15);
    check_eq("clr_hold_peak_pwr", bus.peak_pwr_o, 32'd256);
    @(posedge clk_i);
    #1;
    check_eq("clr_pipe_flushed", bus.pwr_valid_o, 0);
    check_eq("clr_no_peak", n_peak - p0, 0);
    clear_obs();
    send_frames(0, 16);
    wait_drain();
    check_eq("clr_first_bin", obs_bins[0], 0);
    check_eq("clr_count", n_out, 16);
    check_eq("clr_peak_pulses", n_peak - p0, 1);
    check_eq("clr_new_peak_bin", bus.peak_bin_o, 4'd15);

    // ---- Two random back-to-back frames with random downstream ready ----
    clear_obs();
    for (int i = 0; i < 32; i++) frame[i] = $urandom;
    p0 = n_peak;
    tx_done = 1'b0;
    fork
      begin
        send_frames(0, 32);
        tx_done = 1'b1;
      end
      begin
        while (!tx_done) begin
          @(posedge clk_i);
          #1;
          bus.pwr_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.pwr_ready_i = 1'b1;
    wait_drain();
    check_eq("rnd_count", n_out, 32);
    for (int i = 0; i < 32; i++) check_eq("rnd_bin_seq", obs_bins[i], i % 16);
    check_eq("rnd_peak_pulses", n_peak - p0, 2);

    // ---- Asynchronous reset mid-frame ----
    bus.pwr_ready_i = 1'b0;
    frame[0] = 32'h0100_0200;
    frame[1] = 32'h0300_0400;
    frame[2] = 32'h0500_0600;
    send_frames(0, 3);
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("arst_in_ready", bus.fft_in_ready_o, 1);
    check_eq("arst_pwr_valid", bus.pwr_valid_o, 0);
    check_eq("arst_pwr_data", bus.pwr_data_o, 0);
    check_eq("arst_peak_bin", bus.peak_bin_o, 0);
    check_eq("arst_peak_pwr", bus.peak_pwr_o, 0);
    check_eq("arst_peak_valid", bus.peak_valid_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check_eq("arst_stays_empty", bus.pwr_valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_psd_reader.md
# fft_psd_reader

Streaming consumer for the FFT core's complex output port. It accepts one frame of `FFT_SIZE` complex bins over a valid/ready handshake. For each bin it computes the power |X|² in a two-stage pipeline, buffers the results in a small FIFO, and re-emits them downstream with bin index and frame markers. It also reports the peak bin of every frame and sits directly behind the FFT core as its output reader.

## Interface
Parameters:
- `FFT_SIZE`, default 16: bins per frame; must be a power of two, at least 4.
- `DATA_WIDTH`, default 16: signed width of each of re and im.
- `FIFO_DEPTH`, default 4: output FIFO entries; must be a power of two, at least 4.

Ports (`LB` = $clog2(FFT_SIZE), `PW` = 2*DATA_WIDTH):
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `clear_i`  in  1  synchronous flush of pipeline, FIFO, bin counter and peak tracker.
- `fft_in_valid_i`  in  1  input bin valid.
- `fft_in_data_i`  in  PW  {re[PW-1:DATA_WIDTH], im[DATA_WIDTH-1:0]}, both signed two's complement.
- `fft_in_ready_o`  out  1  input ready.
- `pwr_valid_o`  out  1  output power valid.
- `pwr_data_o`  out  PW  unsigned re²+im².
- `pwr_bin_o`  out  LB  bin index of `pwr_data_o`.
- `pwr_last_o`  out  1  high when `pwr_bin_o` == FFT_SIZE-1.
- `pwr_ready_i`  in  1  downstream ready.
- `peak_valid_o`  out  1  one-cycle pulse when a frame's peak is final.
- `peak_bin_o`  out  LB  peak bin of the last completed frame.
- `peak_pwr_o`  out  PW  peak power of the last completed frame.

## Operation
- Input handshake: a bin is accepted on a rising edge where `fft_in_valid_i` && `fft_in_ready_o`.
- Bins arrive in natural order. An LB-bit bin counter increments on each accept and wraps from FFT_SIZE-1 to 0. Input never carries its own index.
- Stage 1 (S1): registers re*re and im*im as unsigned PW-1-bit products, plus the bin tag and a valid bit.
- Stage 2 (S2): sums the two products into PW bits. The maximum (-2^(DW-1))² · 2 = 2^(PW-1) fits without overflow and is never saturated. S2 writes {sum, bin, last} into the FIFO.
- The pipeline never stalls; each stage's valid bit shifts every cycle.
- Credit rule: `fft_in_ready_o` = (fifo_count + S1.valid + S2.valid) < FIFO_DEPTH. This guarantees the FIFO can never overflow.
- The FIFO is first-word-fall-through. `pwr_*` are driven from the head entry. The head is popped on `pwr_valid_o` && `pwr_ready_i`.
- Peak tracker, updated at S2:
  - Bin 0 loads the peak unconditionally.
  - Later bins replace it only if strictly greater, so ties keep the lower bin.
  - When S2 holds bin FFT_SIZE-1, the final {bin, pwr} is copied to `peak_bin_o`/`peak_pwr_o` and `peak_valid_o` pulses on the next cycle.
  - `peak_bin_o`/`peak_pwr_o` hold until the next frame completes.
- `clear_i` empties the FIFO, invalidates S1/S2, zeroes the bin counter and running peak, and suppresses any pending `peak_valid_o`. It does not alter the held `peak_bin_o`/`peak_pwr_o`. During a `clear_i` cycle no input is accepted (`fft_in_ready_o` forced 0) and no pop is counted.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.

## Timing
- Reset values:
  - `fft_in_ready_o`=1
  - `pwr_valid_o`=0, `pwr_data_o`=0, `pwr_bin_o`=0, `pwr_last_o`=0
  - `peak_valid_o`=0, `peak_bin_o`=0, `peak_pwr_o`=0
  - internal counters and FIFO empty.
- Outputs from an empty FIFO read as 0, not stale data.
- Latency: a bin accepted at edge k is in S1 after edge k, in the FIFO after edge k+1, and `pwr_valid_o` is high in the cycle after edge k+1. That is a 2-cycle latency.
- Throughput: one bin per cycle while `pwr_ready_i` stays high.
- `peak_valid_o` is high for exactly the cycle after the edge where bin FFT_SIZE-1 leaves S2. This is the same cycle its power first appears at the FIFO head if the FIFO was empty.
- Reset asserted mid-frame returns every output to its reset value asynchronously; the partial frame is lost.
- `clear_i` and a handshake in the same cycle: `clear_i` wins and the bin is not accepted.

## Test plan
- Impulse frame: bin 3 = {re=0x4000, im=0}, all other bins 0, `pwr_ready_i`=1 → `pwr_data_o`=0x10000000 at bin 3 and 0 elsewhere; `pwr_last_o` at bin 15; `peak_valid_o` pulse with `peak_bin_o`=3, `peak_pwr_o`=0x10000000; first `pwr_valid_o` 2 cycles after the first accept.
- Extreme value: bin {re=-32768, im=-32768} → `pwr_data_o`=0x80000000, with no wrap.
- Backpressure: `pwr_ready_i`=0 for 10 cycles with input always valid → exactly 4 bins accepted, `fft_in_ready_o` low afterwards; releasing `pwr_ready_i` drains bins 0,1,2,3 in order, then input resumes with no loss or duplication.
- Ties: bins 2 and 9 both have power 0x100, all others smaller → `peak_bin_o`=2.
- `clear_i` asserted after 7 accepted bins → FIFO empty next cycle, no `peak_valid_o`, and the next accepted bin is tagged bin 0.
- Two back-to-back frames with random data and random `pwr_ready_i` → 32 outputs in order, `pwr_bin_o` sequence 0..15 twice, two `peak_valid_o` pulses, each matching a reference model.
